// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions, also imported by the control unit.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RET = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

endpackage

// File: rtl/instr_fetch_unit_next_pc_mux.sv
// Next-PC selection: sequential pc+2 (wrapping mod 2^16) or one of three redirects.
module next_pc_mux
  import instr_fetch_unit_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_target,
  input  logic [15:0] jump_target,
  input  logic [15:0] ret_target,
  output logic [15:0] pc_plus2,
  output logic [15:0] next_pc
);

  // Adder plus 4:1 select; redirect targets pass through unchecked.
  always_comb begin
    pc_plus2 = pc + 16'd2;
    next_pc  = pc_plus2;
    case (pc_src)
      PCSRC_BR:  next_pc = branch_target;
      PCSRC_JMP: next_pc = jump_target;
      PCSRC_RET: next_pc = ret_target;
      default:   next_pc = pc_plus2;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: owns the PC, captures the instruction word into IR and
// hands it to the control unit with a valid/advance handshake.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_BYTES = 256,
  parameter int          MEM_LAT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [15:0]          imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [INSTR_W-1:0]   ir,
  output logic                 ir_valid,
  output logic [15:0]          pc,
  output logic [15:0]          pc_plus2,
  input  logic                 advance,
  input  logic [1:0]           pc_src,
  input  logic [15:0]          branch_target,
  input  logic [15:0]          jump_target,
  input  logic [15:0]          ret_target,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  // Compared on 17 bits so a 64 KiB memory still has a representable limit.
  localparam logic [16:0] LAST_ADDR = 17'(IMEM_BYTES - 2);
  localparam logic [2:0]  WAIT_INIT = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  fetch_state_e       state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [15:0]        next_pc;

  next_pc_mux u_next_pc_mux (
    .pc            (pc_q),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .ret_target    (ret_target),
    .pc_plus2      (pc_plus2),
    .next_pc       (next_pc)
  );

  // Next-state logic; each input is honoured only in the state that owns it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pc_q[0]) begin
          fault_code_d = FAULT_MISALIGN;
          state_d      = ST_FAULT;
        end else if ({1'b0, pc_q} > LAST_ADDR) begin
          fault_code_d = FAULT_RANGE;
          state_d      = ST_FAULT;
        end else if (MEM_LAT == 0) begin
          ir_d    = imem_data;
          state_d = ST_VALID;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          ir_d    = imem_data;
          state_d = ST_VALID;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_VALID: begin
        if (advance) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything, including a pending capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      cnt_q        <= 3'd0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = (state_q == ST_VALID);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential fetch front-end of the multi-cycle RISC core: owns the program counter and drives the byte address into the combinational instruction memory. It latches the 16-bit little-endian instruction into the instruction register (IR) and presents it to the control unit through a valid/advance handshake. It also applies the next-PC selection (sequential, branch, jump, return) and traps misaligned or out-of-range fetches.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- IMEM_BYTES, 256, instruction memory size in bytes; the last legal fetch address is IMEM_BYTES-2
- MEM_LAT, 0, extra wait cycles before IR capture (0..7)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; leaves IDLE and begins first fetch
- imem_addr  out  16  byte address to instruction memory (= pc)
- imem_data  in  16  instruction from memory; [7:0]=byte at addr, [15:8]=byte at addr+1
- ir  out  16  latched instruction
- ir_valid  out  1  ir holds a valid instruction for the control unit
- pc  out  16  address of the instruction in ir
- pc_plus2  out  16  pc+2 (link value for call), mod 2^16
- advance  in  1  control unit consumes ir and requests next fetch
- pc_src  in  2  00 pc+2, 01 branch_target, 10 jump_target, 11 ret_target
- branch_target, jump_target, ret_target  in  16 each  redirect addresses from datapath
- fault  out  1  sticky fetch fault
- fault_code  out  2  01 misaligned pc, 10 pc out of range

## Operation
- States: IDLE, FETCH, WAIT, VALID, FAULT.
- Reset values: pc=RESET_PC, ir=16'h0000, ir_valid=0, fault=0, fault_code=00, state IDLE, wait counter 0.
- IDLE: start=1 -> FETCH; otherwise hold. advance is ignored.
- FETCH:
  - pc[0]=1 -> FAULT with code 01.
  - Else pc > IMEM_BYTES-2 -> FAULT with code 10. Misalignment wins if both apply.
  - Else MEM_LAT=0: ir<=imem_data -> VALID.
  - Else MEM_LAT>0: load counter to MEM_LAT-1 -> WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At counter 0: ir<=imem_data -> VALID.
  - imem_addr is held stable throughout.
- VALID:
  - ir_valid=1; ir and pc are held.
  - advance=1: pc<=selected source per pc_src, then -> FETCH; ir_valid drops the next cycle.
  - advance=0: hold indefinitely.
- FAULT:
  - fault=1, ir_valid=0, pc frozen at the faulting address.
  - Only reset exits; start and advance are ignored.
- Arithmetic:
  - pc+2 wraps 16'hFFFE -> 16'h0000.
  - Redirect targets are loaded unchecked; alignment and range are checked at the following FETCH.
- start, advance and pc_src are sampled only in their owning state; they are ignored elsewhere.
- reset dominates every input in every state, including mid-WAIT; it aborts the fetch with no IR update.

## Timing
- imem_addr = pc, combinational from the pc register.
- Memory read is combinational; the capture edge is the end of FETCH (MEM_LAT=0) or the end of the final WAIT cycle.
- Latency from the start or advance edge to ir_valid=1 is 2+MEM_LAT cycles: one edge to enter FETCH, MEM_LAT WAIT cycles, one capture edge.
- Steady-state throughput: one instruction per 2+MEM_LAT cycles when advance is asserted in the first VALID cycle.
- The fault is visible on the cycle after the faulting FETCH.
- pc_plus2 is combinational from pc.

## Structure
- Shared package/header (with the control unit):
  - state encodings;
  - PCSRC_SEQ/BR/JMP/RET constants;
  - FAULT_MISALIGN/FAULT_RANGE codes;
  - instruction width (16).
- One natural sub-module, `next_pc_mux`: a combinational 4:1 select plus the +2 adder. It produces both pc_plus2 and the next-PC value.
- The rest is a single FSM with pc, ir, counter and fault registers.

## Test plan
- Basic fetch:
  - Stimulus: memory bytes 0:0x63, 1:0x53; reset, then start.
  - Required: ir=16'h5363 and pc=0 after 2 cycles with ir_valid=1.
  - Then advance with pc_src=00: pc=2.
- Redirects:
  - In VALID at pc=4, advance with pc_src=01 and branch_target=16'h000C: next ir equals bytes 12/13 and pc=12.
  - Repeat with pc_src=10 to jump_target=0 and with pc_src=11; pc_plus2 reads 6 while pc=4.
- Latency:
  - With MEM_LAT=3: ir_valid rises exactly 5 cycles after start.
  - imem_addr is constant across all WAIT cycles.
  - advance is held low for 10 cycles: ir and ir_valid are stable throughout.
- Faults:
  - jump_target=16'h0007 -> fault=1, fault_code=01, pc=7, ir_valid=0.
  - branch_target=IMEM_BYTES (256) -> fault_code=10.
  - Both faults persist until reset.
- Reset mid-WAIT:
  - With MEM_LAT=2, assert reset during WAIT.
  - Required: pc=RESET_PC, ir=0, state IDLE; no capture occurs.
  - A subsequent start refetches address 0.
- Wrap and ignored inputs:
  - pc=16'hFFFE with IMEM_BYTES=65536: advance with pc_src=00 gives pc=0.
  - advance pulses in IDLE and FETCH have no effect on pc.
